banco_registradores: RTL and testbench
======================================

Name: banco_registradores

Overview:
- Write side of the processor datapath register set: captures the 16-bit internal bus into one of R0..R7 or the instruction register (IR).
- Its outputs feed the bus multiplexer's i0..i7, iR and imediato inputs.
- R7 doubles as the program counter, with a dedicated increment path.
- Issues a one-cycle write acknowledge so the control unit can sequence multi-cycle instructions.

Parameters:
- DATA_W, 16, width of bus, general registers and IR.
- IMM_W, 10, width of the immediate field taken from IR[IMM_W-1:0].
- PC_RESET, 16'h0000, value loaded into R7 on reset.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- bus_in  input  DATA_W  value on the internal bus to be captured.
- wr_en  input  1  write bus_in into the register chosen by wr_sel.
- wr_sel  input  3  destination register index, 0..7.
- ir_load  input  1  write bus_in into IR.
- pc_incr  input  1  increment R7 by 1.
- r0..r7  output  DATA_W each  registered contents of R0..R7.
- ir  output  DATA_W  registered IR contents.
- imediato  output  IMM_W  combinational copy of ir[IMM_W-1:0].
- wr_ack  output  1  registered one-cycle pulse, high the cycle after any accepted write.

Behaviour:
- Reset: resetn low asynchronously forces the following, held while low:
  - r0..r6 = 0 and ir = 0.
  - r7 = PC_RESET.
  - wr_ack = 0.
- Register write: on a rising edge with resetn high and wr_en=1, register[wr_sel] <= bus_in.
  - Only that register changes; all others hold.
- IR load: ir_load=1 gives ir <= bus_in on the same edge.
  - wr_en and ir_load together: both targets load the same bus_in value.
- PC increment: pc_incr=1 gives r7 <= r7 + 1, modulo 2^DATA_W (16'hFFFF wraps to 16'h0000, no carry out).
- R7 priority:
  - wr_en=1 with wr_sel=7 and pc_incr=1 on the same edge: the write wins and the increment is discarded.
  - pc_incr with a write to any other register: both take effect.
- wr_ack: registered as (wr_en | ir_load), so it is high exactly one cycle after each accepted write.
  - Back-to-back writes hold it high continuously.
  - pc_incr alone does not assert it.
- Latency: new values are visible on r*/ir one clock after the enabling edge. imediato follows ir with no extra delay.
- No read-during-write bypass: a same-cycle mux selection sees the old value.
- Reset asserted mid-operation: pending enables are ignored and the outputs go to reset values immediately. The first edge after resetn rises behaves normally.
- Undefined inputs are not special-cased; all enables are sampled only at the rising edge.

Optional Feature:
- Macro BANCO_R0_ZERO_EN.
- Defined:
  - R0 is hardwired to zero and writes to wr_sel=0 are dropped.
  - wr_ack still pulses for such a write, so the control unit timing is unchanged.
  - r0 output is constant 0.
- Undefined: R0 is an ordinary writable register.

Decomposition:
- Shared header processador_defs.vh holds:
  - DATA_W and IMM_W.
  - Register index constants REG_R0..REG_R7, with REG_PC = 7.
- Sub-module registrador: DATA_W-bit register with clock, resetn, load enable and reset value. Instantiated for R0..R6 and IR.
- R7 is built inline, or as a contador_pc variant of registrador with an increment input.
- The one-hot write-enable decode of wr_sel stays in banco_registradores.

Test Plan:
- Reset: hold resetn=0 over two edges with wr_en=1 and bus_in=16'hABCD → all r*=0, r7=PC_RESET, ir=0, wr_ack=0.
- Write sweep: for k=0..7, wr_en=1, wr_sel=k, bus_in=16'h1000+k → next cycle rk=16'h1000+k, other registers unchanged, wr_ack=1 for one cycle.
- IR and immediate: ir_load=1, bus_in=16'hF2A5 → ir=16'hF2A5, imediato=10'h2A5. Same edge with wr_en=1, wr_sel=3 → r3=16'hF2A5.
- PC wrap: write r7=16'hFFFE, then pc_incr for 3 cycles → r7 goes 16'hFFFF, 16'h0000, 16'h0001, and wr_ack stays 0 during the increments.
- R7 conflict: r7=16'h0010, pc_incr=1 together with wr_en=1, wr_sel=7, bus_in=16'h0200 → r7=16'h0200.
- Async reset mid-write: drop resetn between edges while wr_en=1 targets R5 → r5=0 immediately, with no write occurring on the following edge while resetn is low.

Source files
------------

// File: rtl/banco_registradores_pkg.sv
// Shared constants for the datapath register bank: default widths and register indices.
package banco_registradores_pkg;

   localparam int unsigned BANCO_DATA_W = 16;
   localparam int unsigned BANCO_IMM_W  = 10;
   localparam int unsigned NUM_REGS     = 8;

   typedef enum logic [2:0] {
      REG_R0 = 3'd0,
      REG_R1 = 3'd1,
      REG_R2 = 3'd2,
      REG_R3 = 3'd3,
      REG_R4 = 3'd4,
      REG_R5 = 3'd5,
      REG_R6 = 3'd6,
      REG_R7 = 3'd7
   } reg_idx_t;

   // R7 doubles as the program counter
   localparam reg_idx_t REG_PC = REG_R7;

endpackage

// File: rtl/banco_registradores_if.sv
// Write-side bus of the register bank: control unit drives writes, bank returns register contents.
interface banco_registradores_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IMM_W  = 10
);
   logic [DATA_W-1:0] bus_in;
   logic              wr_en;
   logic [2:0]        wr_sel;
   logic              ir_load;
   logic              pc_incr;
   logic [DATA_W-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [DATA_W-1:0] ir;
   logic [IMM_W-1:0]  imediato;
   logic              wr_ack;

   modport master (
      output bus_in, wr_en, wr_sel, ir_load, pc_incr,
      input  r0, r1, r2, r3, r4, r5, r6, r7, ir, imediato, wr_ack
   );

   modport slave (
      input  bus_in, wr_en, wr_sel, ir_load, pc_incr,
      output r0, r1, r2, r3, r4, r5, r6, r7, ir, imediato, wr_ack
   );
endinterface

// File: rtl/banco_registradores_registrador.sv
// registrador: DATA_W-bit load-enabled register with asynchronous active-low reset to RESET_VAL.
module registrador #(
   parameter int unsigned       DATA_W    = 16,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/banco_registradores.sv
// banco_registradores: R0..R7 and IR write side; R7 is the PC with its own increment path.
// Optional BANCO_R0_ZERO_EN hardwires R0 to zero (writes dropped, wr_ack unchanged).
module banco_registradores
   import banco_registradores_pkg::*;
#(
   parameter int unsigned       DATA_W   = BANCO_DATA_W,
   parameter int unsigned       IMM_W    = BANCO_IMM_W,
   parameter logic [DATA_W-1:0] PC_RESET = '0
) (
   input  logic                  clock,
   input  logic                  resetn,
   banco_registradores_if.slave  rb
);

   logic [NUM_REGS-1:0] wr_onehot;
   logic [DATA_W-1:0]   r0_q;
   logic [DATA_W-1:0]   gpr [1:NUM_REGS-2];
   logic [DATA_W-1:0]   pc_q;
   logic [DATA_W-1:0]   ir_q;
   logic                wr_ack_q;

   always_comb begin
      wr_onehot = '0;
      if (rb.wr_en) begin
         wr_onehot[rb.wr_sel] = 1'b1;
      end
   end

`ifdef BANCO_R0_ZERO_EN
   assign r0_q = '0;
`else
   registrador #(.DATA_W(DATA_W), .RESET_VAL('0)) u_r0 (
      .clock  (clock),
      .resetn (resetn),
      .load   (wr_onehot[REG_R0]),
      .d      (rb.bus_in),
      .q      (r0_q)
   );
`endif

   for (genvar k = 1; k < NUM_REGS - 1; k++) begin : g_gpr
      registrador #(.DATA_W(DATA_W), .RESET_VAL('0)) u_reg (
         .clock  (clock),
         .resetn (resetn),
         .load   (wr_onehot[k]),
         .d      (rb.bus_in),
         .q      (gpr[k])
      );
   end

   // An explicit write to R7 overrides a same-edge increment
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc_q <= PC_RESET;
      end else if (wr_onehot[REG_PC]) begin
         pc_q <= rb.bus_in;
      end else if (rb.pc_incr) begin
         pc_q <= pc_q + DATA_W'(1);
      end
   end

   registrador #(.DATA_W(DATA_W), .RESET_VAL('0)) u_ir (
      .clock  (clock),
      .resetn (resetn),
      .load   (rb.ir_load),
      .d      (rb.bus_in),
      .q      (ir_q)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ack_q <= 1'b0;
      end else begin
         wr_ack_q <= rb.wr_en | rb.ir_load;
      end
   end

   assign rb.r0       = r0_q;
   assign rb.r1       = gpr[1];
   assign rb.r2       = gpr[2];
   assign rb.r3       = gpr[3];
   assign rb.r4       = gpr[4];
   assign rb.r5       = gpr[5];
   assign rb.r6       = gpr[6];
   assign rb.r7       = pc_q;
   assign rb.ir       = ir_q;
   assign rb.imediato = ir_q[IMM_W-1:0];
   assign rb.wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: array model compared every negedge plus literal checks.
module tb_banco_registradores;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned IMM_W    = 10;
   localparam logic [15:0] PC_RESET = 16'h0000;
`ifdef BANCO_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   int   n_checks = 0;
   int   n_err    = 0;
   bit   chk_en   = 1'b0;

   banco_registradores_if #(.DATA_W(DATA_W), .IMM_W(IMM_W)) bif ();

   banco_registradores #(.DATA_W(DATA_W), .IMM_W(IMM_W), .PC_RESET(PC_RESET)) dut (
      .clock  (clock),
      .resetn (resetn),
      .rb     (bif.slave)
   );

   always #5 clock = ~clock;

   // Model: eight plain registers, IR and ack, updated by the write rules
   logic [15:0] exp_r [8];
   logic [15:0] exp_ir;
   logic        exp_ack;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 8; i++) exp_r[i] <= 16'h0000;
         exp_r[7] <= PC_RESET;
         exp_ir   <= 16'h0000;
         exp_ack  <= 1'b0;
      end else begin
         if (bif.pc_incr) exp_r[7] <= exp_r[7] + 16'h0001;
         // Later NBA overrides the increment when the write targets R7
         if (bif.wr_en && !(R0Z && bif.wr_sel == 3'd0)) exp_r[bif.wr_sel] <= bif.bus_in;
         if (bif.ir_load) exp_ir <= bif.bus_in;
         exp_ack <= bif.wr_en | bif.ir_load;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] dut_reg(input int k);
      case (k)
         0: return bif.r0;
         1: return bif.r1;
         2: return bif.r2;
         3: return bif.r3;
         4: return bif.r4;
         5: return bif.r5;
         6: return bif.r6;
         default: return bif.r7;
      endcase
   endfunction

   always @(negedge clock) begin
      if (chk_en) begin
         for (int k = 0; k < 8; k++) check($sformatf("model_r%0d", k), 32'(dut_reg(k)), 32'(exp_r[k]));
         check("model_ir", 32'(bif.ir), 32'(exp_ir));
         check("model_imm", 32'(bif.imediato), 32'(exp_ir[9:0]));
         check("model_ack", 32'(bif.wr_ack), 32'(exp_ack));
      end
   end

   task automatic step(input logic we, input logic [2:0] sel, input logic il,
                       input logic pi, input logic [15:0] d);
      bif.wr_en   = we;
      bif.wr_sel  = sel;
      bif.ir_load = il;
      bif.pc_incr = pi;
      bif.bus_in  = d;
      @(posedge clock);
      #1;
   endtask

   initial begin
      bif.wr_en   = 1'b1;
      bif.wr_sel  = 3'd5;
      bif.ir_load = 1'b0;
      bif.pc_incr = 1'b0;
      bif.bus_in  = 16'hABCD;
      repeat (2) @(posedge clock);
      #1;
      chk_en = 1'b1;
      check("rst_r5", 32'(bif.r5), 32'h0);
      check("rst_r7", 32'(bif.r7), 32'(PC_RESET));
      check("rst_ir", 32'(bif.ir), 32'h0);
      check("rst_ack", 32'(bif.wr_ack), 32'h0);
      resetn = 1'b1;
      bif.wr_en = 1'b0;

      for (int k = 0; k < 8; k++) begin
         step(1'b1, 3'(k), 1'b0, 1'b0, 16'h1000 + 16'(k));
         check($sformatf("sweep_r%0d", k), 32'(dut_reg(k)),
               (R0Z && k == 0) ? 32'h0 : 32'h1000 + 32'(k));
         check("sweep_ack", 32'(bif.wr_ack), 32'h1);
      end
      step(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      check("ack_drop", 32'(bif.wr_ack), 32'h0);
      check("sweep_r6_hold", 32'(bif.r6), 32'h1006);

      step(1'b1, 3'd3, 1'b1, 1'b0, 16'hF2A5);
      check("ir_val", 32'(bif.ir), 32'hF2A5);
      check("imm_val", 32'(bif.imediato), 32'h2A5);
      check("ir_r3", 32'(bif.r3), 32'hF2A5);
      check("ir_r4_hold", 32'(bif.r4), 32'h1004);

      step(1'b1, 3'd7, 1'b0, 1'b0, 16'hFFFE);
      step(1'b0, 3'd0, 1'b0, 1'b1, 16'h0000);
      check("pc_ffff", 32'(bif.r7), 32'hFFFF);
      check("pc_ack0", 32'(bif.wr_ack), 32'h0);
      step(1'b0, 3'd0, 1'b0, 1'b1, 16'h0000);
      check("pc_wrap", 32'(bif.r7), 32'h0000);
      step(1'b0, 3'd0, 1'b0, 1'b1, 16'h0000);
      check("pc_0001", 32'(bif.r7), 32'h0001);
      check("pc_ack0b", 32'(bif.wr_ack), 32'h0);

      step(1'b1, 3'd7, 1'b0, 1'b0, 16'h0010);
      step(1'b1, 3'd7, 1'b0, 1'b1, 16'h0200);
      check("pc_conflict", 32'(bif.r7), 32'h0200);
      step(1'b1, 3'd2, 1'b0, 1'b1, 16'h0BEE);
      check("incr_r2", 32'(bif.r2), 32'h0BEE);
      check("incr_r7", 32'(bif.r7), 32'h0201);
      check("incr_ack", 32'(bif.wr_ack), 32'h1);

      step(1'b1, 3'd5, 1'b0, 1'b0, 16'h5555);
      check("pre_rst_r5", 32'(bif.r5), 32'h5555);
      bif.bus_in = 16'h7777;
      #2;
      resetn = 1'b0;
      #1;
      check("arst_r5", 32'(bif.r5), 32'h0);
      check("arst_r7", 32'(bif.r7), 32'(PC_RESET));
      check("arst_ack", 32'(bif.wr_ack), 32'h0);
      @(posedge clock);
      #1;
      check("arst_hold_r5", 32'(bif.r5), 32'h0);
      resetn = 1'b1;
      step(1'b1, 3'd5, 1'b0, 1'b0, 16'h1234);
      check("post_rst_r5", 32'(bif.r5), 32'h1234);
      step(1'b0, 3'd0, 1'b0, 1'b0, 16'h0000);
      @(negedge clock);
      #1;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
